// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the block-RAM controller: state encoding, default widths
// and the power-on fill pattern, also usable by a RAM golden model.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam logic [15:0] DEF_INIT_BASE = 16'h55FF;
  localparam int unsigned DEF_INIT_STEP = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    INIT
  } state_e;

  // Power-on word for a given address; wraps modulo 2**DEF_DATA_W.
  function automatic logic [DEF_DATA_W-1:0] init_word(input logic [DEF_ADDR_W-1:0] a);
    return DEF_INIT_BASE - DEF_DATA_W'(DEF_INIT_STEP) * DEF_DATA_W'(a);
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// CPU-side load/store handshake between the datapath (master) and ram_ctrl (slave).
interface ram_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req,
    output rw,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  rw,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/ram_init_seq.sv
// Re-initialisation sweep sequencer: address counter, decrementing data generator
// and terminal-count detection for the block-RAM fill.
module ram_init_seq
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_BASE = DATA_W'(DEF_INIT_BASE),
  parameter int unsigned       INIT_STEP = DEF_INIT_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              active,
  output logic              last,
  output logic [ADDR_W-1:0] nxt_addr,
  output logic [DATA_W-1:0] nxt_data
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              active_q, active_d;

  // cnt_q tracks the address currently presented to the RAM during the sweep.
  assign nxt_addr = cnt_q + 1'b1;
  assign nxt_data = INIT_BASE - DATA_W'(INIT_STEP) * DATA_W'(nxt_addr);
  assign last     = active_q && (cnt_q == '1);
  assign active   = active_q;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      cnt_d = nxt_addr;
      if (last) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Single-master controller for a synchronous single-port block RAM: sequences CPU
// loads/stores, absorbs the 1-cycle read latency and runs the re-init sweep.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] INIT_BASE = DATA_W'(DEF_INIT_BASE),
  parameter int unsigned       INIT_STEP = DEF_INIT_STEP
) (
  input  logic              clk,
  input  logic              reset,
  ram_ctrl_if.slave         cpu,
  output logic              busy,
  input  logic              init_start,
  output logic              init_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              init_done_q, init_done_d;

  logic              init_go;
  logic              init_active;
  logic              init_last;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  ram_init_seq #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_BASE (INIT_BASE),
    .INIT_STEP (INIT_STEP)
  ) u_init_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (init_go),
    .active   (init_active),
    .last     (init_last),
    .nxt_addr (init_addr),
    .nxt_data (init_data)
  );

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 1'b0;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    init_done_d = 1'b0;
    init_go     = 1'b0;

    case (state_q)
      IDLE: begin
        // init_start wins over a simultaneous req; the req stays pending.
        if (init_start) begin
          init_go    = 1'b1;
          ram_addr_d = '0;
          ram_din_d  = INIT_BASE;
          ram_we_d   = 1'b1;
          state_d    = INIT;
        end else if (cpu.req) begin
          ram_addr_d = cpu.addr;
          if (cpu.rw) begin
            ram_din_d = cpu.wdata;
            ram_we_d  = 1'b1;
            state_d   = WR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end

      WR: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end

      RD_ADDR: begin
        state_d = RD_DATA;
      end

      RD_DATA: begin
        rdata_d = ram_dout;
        ack_d   = 1'b1;
        state_d = IDLE;
      end

      INIT: begin
        // The last word is written at this edge; the counter wraps to zero.
        if (init_last) begin
          ram_addr_d  = init_addr;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end else if (init_active) begin
          ram_addr_d = init_addr;
          ram_din_d  = init_data;
          ram_we_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign cpu.rdata = rdata_q;
  assign cpu.ack   = ack_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != IDLE);

  ack_done_excl: assert property (@(posedge clk) disable iff (reset)
    !(ack_q && init_done_q));

  ack_single_pulse: assert property (@(posedge clk) disable iff (reset)
    ack_q |=> !ack_q);

  done_single_pulse: assert property (@(posedge clk) disable iff (reset)
    init_done_q |=> !init_done_q);

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural 256x16 synchronous RAM holding
// the power-on pattern (address a holds 55FFh - a).
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_start = 1'b0;
  logic        busy;
  logic        init_done;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  int checks = 0;
  int errors = 0;

  ram_ctrl_if #(.ADDR_W(8), .DATA_W(16)) cpu_if ();

  ram_ctrl #(
    .ADDR_W    (8),
    .DATA_W    (16),
    .INIT_BASE (16'h55FF),
    .INIT_STEP (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_if),
    .busy       (busy),
    .init_start (init_start),
    .init_done  (init_done),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM model with power-on contents.
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h55FF - 16'(i);
    ram_dout = '0;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [15:0] d,
                        output int lat, output int we_cnt,
                        output logic [7:0] we_a, output logic [15:0] we_d);
    cpu_if.req   = 1'b1;
    cpu_if.rw    = w;
    cpu_if.addr  = a;
    cpu_if.wdata = d;
    lat = 0; we_cnt = 0; we_a = '0; we_d = '0;
    do begin
      @(negedge clk);
      lat++;
      if (ram_we) begin
        we_cnt++;
        we_a = ram_addr;
        we_d = ram_din;
      end
    end while (!cpu_if.ack && lat < 20);
    cpu_if.req = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [7:0] a, input logic [15:0] exp);
    int lat, wc; logic [7:0] wa; logic [15:0] wd;
    access(1'b0, a, 16'h0000, lat, wc, wa, wd);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_we"}, wc, 0);
    check({tag, "_rdata"}, cpu_if.rdata, exp);
  endtask

  task automatic do_store(input string tag, input logic [7:0] a, input logic [15:0] d);
    int lat, wc; logic [7:0] wa; logic [15:0] wd;
    access(1'b1, a, d, lat, wc, wa, wd);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_we"}, wc, 1);
    check({tag, "_addr"}, wa, a);
    check({tag, "_din"}, wd, d);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n, nw, seq_err, acks, dn, done_at, ack_at, a1, a2;
    logic [15:0] d0, d1, dff;
    logic [7:0]  aff;
    logic        b4;

    cpu_if.req = 1'b0; cpu_if.rw = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", cpu_if.rdata, 0);
    check("rst_ack", cpu_if.ack, 0);
    check("rst_busy", busy, 0);
    check("rst_done", init_done, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    reset = 1'b0;
    @(negedge clk);

    do_load("ld00", 8'h00, 16'h55FF);
    do_load("ld10", 8'h10, 16'h55EF);
    do_store("st3c", 8'h3C, 16'hBEEF);
    do_load("ld3c", 8'h3C, 16'hBEEF);
    do_store("st90", 8'h90, 16'h1234);
    do_load("ld90", 8'h90, 16'h1234);

    // Full sweep.
    init_start = 1'b1;
    n = 0; nw = 0; seq_err = 0; acks = 0;
    d0 = '0; d1 = '0; dff = '0; aff = '0;
    do begin
      @(negedge clk);
      n++;
      init_start = 1'b0;
      if (cpu_if.ack) acks++;
      if (ram_we) begin
        if (ram_addr !== 8'(nw) || ram_din !== 16'h55FF - 16'(nw)) seq_err++;
        if (nw == 0) d0 = ram_din;
        if (nw == 1) d1 = ram_din;
        if (nw == 255) begin aff = ram_addr; dff = ram_din; end
        nw++;
      end
    end while (!init_done && n < 400);
    check("sw_done", init_done, 1);
    check("sw_writes", nw, 256);
    check("sw_seq", seq_err, 0);
    check("sw_d00", d0, 16'h55FF);
    check("sw_d01", d1, 16'h55FE);
    check("sw_aff", aff, 8'hFF);
    check("sw_dff", dff, 16'h5500);
    check("sw_busy", busy, 0);
    check("sw_noack", acks, 0);
    @(negedge clk);
    check("sw_done_pulse", init_done, 0);
    do_load("ld3c_init", 8'h3C, 16'h55C3);

    // init_start and a load in the same cycle.
    init_start = 1'b1;
    cpu_if.req = 1'b1; cpu_if.rw = 1'b0; cpu_if.addr = 8'h05;
    n = 0; done_at = 0; ack_at = 0;
    do begin
      @(negedge clk);
      n++;
      init_start = 1'b0;
      if (init_done) done_at = n;
      if (cpu_if.ack) ack_at = n;
    end while (ack_at == 0 && n < 400);
    cpu_if.req = 1'b0;
    check("sim_done_at", done_at, 257);
    check("sim_ack_at", ack_at, 260);
    check("sim_rdata", cpu_if.rdata, 16'h55FA);

    // Reset in the middle of a sweep.
    do_store("st90b", 8'h90, 16'h1234);
    init_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      init_start = 1'b0;
    end while (!(ram_we && ram_addr == 8'h80) && n < 400);
    check("mid_at80", n, 129);
    reset = 1'b1;
    @(negedge clk);
    check("mid_we", ram_we, 0);
    check("mid_busy", busy, 0);
    check("mid_done", init_done, 0);
    reset = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (init_done) dn++;
    end
    check("mid_no_done", dn, 0);
    do_load("ld90_mid", 8'h90, 16'h1234);

    // Back-to-back loads with req held through the first ack.
    cpu_if.req = 1'b1; cpu_if.rw = 1'b0; cpu_if.addr = 8'h3C;
    acks = 0; a1 = 0; a2 = 0; b4 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 4) b4 = busy;
      if (cpu_if.ack) begin
        acks++;
        check("b2b_rdata", cpu_if.rdata, 16'h55C3);
        if (acks == 1) a1 = i;
        else a2 = i;
        if (acks == 2) cpu_if.req = 1'b0;
      end
    end
    cpu_if.req = 1'b0;
    check("b2b_acks", acks, 2);
    check("b2b_ack1", a1, 3);
    check("b2b_ack2", a2, 6);
    check("b2b_busy", b4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Memory-side controller sitting directly upstream of the 256x16 single-port block RAM; it is the only master driving that RAM.
- Accepts load/store requests from the CPU datapath over a req/ack handshake.
- Sequences RAM address, write-enable and write data, and absorbs the RAM's 1-cycle synchronous read latency.
- Provides an on-demand re-initialisation sweep that restores the RAM power-on pattern: address 00h holds 55FFh, and each later address holds one less.

Parameters:
ADDR_W, 8, RAM address width (depth = 2**ADDR_W = 256)
DATA_W, 16, data width
INIT_BASE, 16'h55FF, value written to address 0 during init sweep
INIT_STEP, 1, decrement per address during init sweep

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
req  input  1  CPU access request; held high until ack
rw  input  1  1 = store, 0 = load; sampled with req
addr  input  ADDR_W  CPU word address
wdata  input  DATA_W  store data
rdata  output  DATA_W  load data, valid in ack cycle, held until next load completes
ack  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
init_start  input  1  request re-initialisation sweep
init_done  output  1  one-cycle pulse when sweep completes
ram_we  output  1  to RAM write enable
ram_addr  output  ADDR_W  to RAM address
ram_din  output  DATA_W  to RAM write data
ram_dout  input  DATA_W  from RAM read data (valid one edge after address sampled)

Behaviour:
- Interface decision: one clock (`clk`); reset (`reset`) is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values: all outputs are 0. This covers rdata, ack, busy, init_done, ram_we, ram_addr and ram_din. State resets to IDLE.
- All RAM-side outputs are registered.
- States: IDLE, RD_ADDR, RD_DATA, WR, INIT.
- IDLE, priority order at an edge with no reset: init_start first, then req, else stay in IDLE.
  - init_start = 1: load ram_addr = 0, ram_din = INIT_BASE, ram_we = 1; go to INIT.
  - req & rw = 1: ram_addr = addr, ram_din = wdata, ram_we = 1; go to WR.
  - req & rw = 0: ram_addr = addr, ram_we = 0; go to RD_ADDR.
- WR: at the next edge the RAM writes. ram_we drops to 0, ack = 1 for one cycle, return to IDLE. Store latency is 2 cycles from the req-sampling edge to the ack-high cycle.
- RD_ADDR: the RAM samples ram_addr at this edge. Go to RD_DATA.
- RD_DATA: capture rdata <= ram_dout, pulse ack, return to IDLE. Load latency is 3 cycles from the req-sampling edge to the ack-high cycle.
- Handshake rules:
  - req is sampled only in IDLE; it is ignored while busy.
  - The requester holds req/rw/addr/wdata stable until it sees ack.
  - If req is still high in the cycle after ack, it is treated as a new request. The requester must drop req in the ack cycle to avoid a repeat access.
- INIT sweep:
  - Each cycle: ram_we = 1, ram_addr increments by 1, ram_din = INIT_BASE − INIT_STEP*ram_addr. This is modulo 2**DATA_W, so it wraps below 0000h without saturation.
  - After address FFh is written (ram_addr wraps to 00h internally), ram_we = 0, init_done pulses one cycle, return to IDLE.
  - Duration is 256 write cycles.
  - A req arriving during INIT stays pending and is accepted in the first IDLE cycle.
  - init_start during a non-IDLE state is ignored and is not queued.
- Simultaneous init_start and req in IDLE: the init sweep runs first, then req is serviced.
- Reset mid-operation: the same edge forces IDLE and ram_we = 0. A pending store whose write edge has not occurred is lost. A partial sweep leaves the RAM partially re-initialised. No ack or init_done is issued for the aborted operation.
- ack and init_done are never high in the same cycle.

Decomposition:
- Shared package holds the state enum (IDLE, RD_ADDR, RD_DATA, WR, INIT), ADDR_W/DATA_W defaults, and INIT_BASE/INIT_STEP constants. The package is reusable by the RAM testbench golden model.
- One natural sub-module, ram_init_seq. It contains the 8-bit address counter, the decrementing data generator and terminal-count detection, with start/active/last outputs.

Test Plan:
- Reset then IDLE: all outputs 0, busy = 0 → after any load, with no prior store or init, rdata equals the RAM's power-on contents, e.g. address 00h → 55FFh and 10h → 55EFh.
- Store addr = 3Ch, wdata = BEEFh → ram_we high exactly one cycle with ram_addr = 3Ch, ack 2 cycles after req is sampled. A following load from 3Ch → rdata = BEEFh, ack 3 cycles after req.
- Init sweep: init_start pulse → 256 consecutive writes; address 00h → 55FFh, 01h → 55FEh, FFh → 5500h. init_done pulses once, busy falls in the same cycle.
- init_start and req (load from 05h) asserted in the same cycle → sweep runs first; the load acks after init_done with rdata = 55FAh.
- Reset asserted at sweep address 80h → ram_we = 0 at that edge, no init_done. A load from 90h returns the pre-init value, e.g. 1234h if stored earlier.
- Back-to-back loads with req held through ack → second access starts in the cycle after ack, with no lost or duplicated ack.
